// File: rtl/microwave_timer.sv
// microwave_timer: keypad-loaded BCD MM:SS countdown that flags expiry to the magnetron control block
module microwave_timer #(
   parameter int TICKS_PER_SEC = 100
)(
   input  logic       clk,
   input  logic       resetn,
   input  logic       digit_valid,
   input  logic [3:0] digit,
   input  logic       clearn,
   input  logic       mag_on,
   output logic [3:0] min_tens,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       timer_done,
   output logic       time_zero
);
   localparam int CW = $clog2(TICKS_PER_SEC);
   localparam logic [CW-1:0] LAST = CW'(TICKS_PER_SEC - 1);
   localparam logic [1:0] IDLE = 2'd0, SET = 2'd1, RUN = 2'd2, DONE = 2'd3;
   logic [3:0]    r_mt, r_mo, r_st, r_so;
   logic [CW-1:0] r_pre;
   logic [1:0]    r_state;
   logic [3:0]    w_dmt, w_dmo, w_dst, w_dso;
   logic          w_b0, w_b1, w_b2, w_tick, w_key, w_key_zero, w_dec_zero;
   // one-second BCD decrement; seconds tens wrap to 5 so 1:00 becomes 0:59
   always_comb begin
      w_b0  = r_so == 4'd0;
      w_b1  = w_b0 && r_st == 4'd0;
      w_b2  = w_b1 && r_mo == 4'd0;
      w_dso = w_b0 ? 4'd9 : r_so - 4'd1;
      w_dst = w_b0 ? (r_st == 4'd0 ? 4'd5 : r_st - 4'd1) : r_st;
      w_dmo = w_b1 ? (r_mo == 4'd0 ? 4'd9 : r_mo - 4'd1) : r_mo;
      w_dmt = w_b2 ? r_mt - 4'd1 : r_mt;
   end
   assign w_tick     = r_pre == LAST;
   assign w_dec_zero = {w_dmt, w_dmo, w_dst, w_dso} == 16'd0;
   assign w_key      = digit_valid && digit <= 4'd9 && r_state != RUN;
   assign w_key_zero = {r_mo, r_st, r_so, digit} == 16'd0;
   assign time_zero  = {r_mt, r_mo, r_st, r_so} == 16'd0;
   assign timer_done = r_state == DONE;
   assign min_tens   = r_mt;
   assign min_ones   = r_mo;
   assign sec_tens   = r_st;
   assign sec_ones   = r_so;
   always_ff @(posedge clk) begin
      if (!resetn || !clearn) begin
         {r_mt, r_mo, r_st, r_so} <= 16'd0;
         r_pre   <= '0;
         r_state <= IDLE;
      end else if (r_state == RUN) begin
         if (!mag_on) begin
            r_state <= SET;
            r_pre   <= '0;
         end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
               {r_mt, r_mo, r_st, r_so} <= {w_dmt, w_dmo, w_dst, w_dso};
               if (w_dec_zero) r_state <= DONE;
            end
         end
      end else if (mag_on && r_state != DONE) begin
         r_state <= (r_state == IDLE) ? DONE : RUN;
      end else if (w_key) begin
         {r_mt, r_mo, r_st, r_so} <= {r_mo, r_st, r_so, digit};
         r_state <= w_key_zero ? IDLE : SET;
      end
   end
endmodule

// File: tb/tb_microwave_timer.sv
// tb_microwave_timer: directed and randomized checks of microwave_timer against a seconds-level model
module tb_microwave_timer;
   localparam int T = 4;
   logic       clk = 1'b0, resetn = 1'b0, digit_valid = 1'b0, clearn = 1'b1, mag_on = 1'b0;
   logic [3:0] digit = 4'd0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic       timer_done, time_zero;
   int n_checks = 0, n_err = 0;
   int mm = 0, ss = 0, cnt = 0;
   bit running = 0, expired = 0;

   microwave_timer #(.TICKS_PER_SEC(T)) dut (
      .clk(clk), .resetn(resetn), .digit_valid(digit_valid), .digit(digit),
      .clearn(clearn), .mag_on(mag_on), .min_tens(min_tens), .min_ones(min_ones),
      .sec_tens(sec_tens), .sec_ones(sec_ones), .timer_done(timer_done), .time_zero(time_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] bcd(int m, int s);
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // model works in minutes and seconds; display digits are derived only for comparison
   function automatic void model_edge();
      if (!resetn || !clearn) begin
         mm = 0; ss = 0; cnt = 0; running = 0; expired = 0;
      end else if (running) begin
         if (!mag_on) begin
            running = 0; cnt = 0;
         end else if (++cnt == T) begin
            cnt = 0;
            if (ss > 0) ss--; else begin ss = 59; mm--; end
            if (mm == 0 && ss == 0) begin running = 0; expired = 1; end
         end
      end else if (mag_on && !expired) begin
         if (mm == 0 && ss == 0) expired = 1; else running = 1;
      end else if (digit_valid && digit <= 9) begin
         mm = (mm % 10) * 10 + ss / 10;
         ss = (ss % 10) * 10 + int'(digit);
         expired = 0;
      end
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic run(int n);
      repeat (n) step();
   endtask

   task automatic key(logic [3:0] d);
      digit_valid = 1'b1; digit = d;
      step();
      digit_valid = 1'b0;
   endtask

   task automatic clear();
      clearn = 1'b0;
      step();
      clearn = 1'b1;
   endtask

   function automatic logic [15:0] disp();
      return {min_tens, min_ones, sec_tens, sec_ones};
   endfunction

   initial begin
      // T1: reset overrides mag_on and keys
      mag_on = 1'b1; digit_valid = 1'b1; digit = 4'd5;
      repeat (3) begin
         step();
         chk("reset_disp", disp(), 16'h0000);
         chk("reset_done", timer_done, 1'b0);
      end
      resetn = 1'b1; mag_on = 1'b0; digit_valid = 1'b0;
      // T2: entry, invalid key ignored
      key(1); key(2); key(3); key(4); key(12);
      chk("entry_disp", disp(), 16'h1234);
      chk("entry_zero", time_zero, 1'b0);
      mag_on = 1'b1; step();
      chk("entry_set_not_done", timer_done, 1'b0);
      mag_on = 1'b0; step(); clear();
      // T3: countdown to expiry, counted from the edge entering RUN
      key(2);
      chk("cd_loaded", disp(), 16'h0002);
      mag_on = 1'b1; step();
      run(3);
      chk("cd_before_tick", disp(), 16'h0002);
      step();
      chk("cd_edge4", disp(), 16'h0001);
      run(4);
      chk("cd_edge8", disp(), 16'h0000);
      chk("cd_done", timer_done, 1'b1);
      chk("cd_zero", time_zero, 1'b1);
      run(5);
      chk("cd_hold_disp", disp(), 16'h0000);
      chk("cd_hold_done", timer_done, 1'b1);
      mag_on = 1'b0; step(); clear();
      // T4: borrow chains and the 99:99 maximum
      key(1); key(0); key(0);
      mag_on = 1'b1; step(); run(4);
      chk("borrow_1m", disp(), 16'h0059);
      mag_on = 1'b0; step(); clear();
      key(1); key(0); key(0); key(0);
      mag_on = 1'b1; step(); run(4);
      chk("borrow_10m", disp(), 16'h0959);
      mag_on = 1'b0; step(); clear();
      key(9); key(9); key(9); key(9);
      mag_on = 1'b1; step(); run(4);
      chk("max_9999", disp(), 16'h9998);
      mag_on = 1'b0; step(); clear();
      // T5: pause and resume
      key(5);
      mag_on = 1'b1; step(); run(6);
      chk("pause_run", disp(), 16'h0004);
      mag_on = 1'b0; run(10);
      chk("pause_hold", disp(), 16'h0004);
      mag_on = 1'b1; step(); run(4);
      chk("pause_resume", disp(), 16'h0003);
      // T6: clear mid-run, abort from idle, collisions
      clear();
      chk("clr_disp", disp(), 16'h0000);
      chk("clr_done", timer_done, 1'b0);
      step();
      chk("abort_done", timer_done, 1'b1);
      mag_on = 1'b0;
      clearn = 1'b0; digit_valid = 1'b1; digit = 4'd7;
      step();
      clearn = 1'b1; digit_valid = 1'b0;
      chk("clr_key_disp", disp(), 16'h0000);
      chk("clr_key_done", timer_done, 1'b0);
      mag_on = 1'b1; step(); mag_on = 1'b0; step();
      chk("done_held", timer_done, 1'b1);
      key(5);
      chk("done_key_disp", disp(), 16'h0005);
      chk("done_key_done", timer_done, 1'b0);
      // randomized traffic against the model
      repeat (600) begin
         resetn = $urandom_range(0, 149) != 0;
         clearn = $urandom_range(0, 79) != 0;
         if ($urandom_range(0, 24) == 0) mag_on = ~mag_on;
         digit_valid = $urandom_range(0, 5) == 0;
         digit = 4'($urandom_range(0, 15));
         step();
         chk("rnd_disp", disp(), bcd(mm, ss));
         chk("rnd_done", timer_done, expired);
         chk("rnd_zero", time_zero, mm == 0 && ss == 0);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
